latency_result_arbiter: RTL

LATENCY_RESULT_ARBITER -- requirements
Module: latency_result_arbiter

---
 rtl/latency_result_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/latency_result_arbiter.sv
// latency_result_arbiter
// Round-robin arbiter that lets NCH latency-measurement channels share one
// SPI slave. A granted channel's 32-bit result is captured into a shadow
// register and streamed as a header byte followed by four data bytes,
// least significant byte first. Whenever no frame is loaded, IDLE_BYTE is
// presented to the slave.
//
// Optional feature: define LAT_CRC_EN to append a sixth byte. That byte is
// the XOR of the header and the four data bytes.
module latency_result_arbiter #(
  parameter int         NCH       = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [32*NCH-1:0] req_data,
  output logic [NCH-1:0]    req_ack,
  input  logic              byte_done,
  input  logic              ssel,
  output logic [7:0]        byte_data_send,
  output logic              busy,
  output logic [1:0]        last_grant
);

`ifdef LAT_CRC_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state;
  logic [2:0]     idx;
  logic [31:0]    shadow;
  logic           ssel_q;
  logic           ssel_rise;
  logic [2:0]     next_idx;

  logic [3:0]     valid4;
  logic [1:0]     cand;
  logic [1:0]     win;
  logic           found;
  logic [NCH-1:0] grant_vec;
  logic [31:0]    win_data;

  assign ssel_rise = ssel & ~ssel_q;
  assign next_idx  = idx + 3'd1;
  assign valid4    = 4'(req_valid);

  function automatic logic [7:0] header_byte(input logic [1:0] ch);
    return {6'b101000, ch};
  endfunction

`ifdef LAT_CRC_EN
  function automatic logic [7:0] crc_byte(input logic [1:0] ch, input logic [31:0] d);
    return header_byte(ch) ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
  endfunction
`endif

  // Byte to present at frame position i. Position 0 is the header.
  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [1:0] ch,
                                            input logic [31:0] d);
    logic [7:0] b;
    case (i)
      3'd0:    b = header_byte(ch);
      3'd1:    b = d[7:0];
      3'd2:    b = d[15:8];
      3'd3:    b = d[23:16];
      3'd4:    b = d[31:24];
`ifdef LAT_CRC_EN
      3'd5:    b = crc_byte(ch, d);
`endif
      default: b = IDLE_BYTE;
    endcase
    return b;
  endfunction

  // Round-robin search: first requesting channel after last_grant, wrapping at NCH.
  always_comb begin
    cand  = 2'd0;
    win   = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      cand = 2'((int'(last_grant) + i) % NCH);
      if (!found && valid4[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Decode the winner into an ack vector and select its result word.
  always_comb begin
    grant_vec = '0;
    win_data  = 32'd0;
    for (int k = 0; k < NCH; k++) begin
      if (win == 2'(k)) begin
        grant_vec[k] = 1'b1;
        win_data     = req_data[32*k +: 32];
      end
    end
  end

  // Control FSM: arbitration in IDLE, byte sequencing and ssel-restart in SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= 3'd0;
      shadow         <= 32'd0;
      req_ack        <= '0;
      busy           <= 1'b0;
      byte_data_send <= IDLE_BYTE;
      last_grant     <= 2'(NCH - 1);
      ssel_q         <= 1'b1;
    end else begin
      ssel_q  <= ssel;
      req_ack <= '0;
      case (state)
        IDLE: begin
          // Only arbitrate between transfers so a frame never starts mid-transfer.
          if (ssel && found) begin
            shadow         <= win_data;
            req_ack        <= grant_vec;
            last_grant     <= win;
            byte_data_send <= header_byte(win);
            idx            <= 3'd0;
            busy           <= 1'b1;
            state          <= SEND;
          end
        end
        SEND: begin
          // A master deselect before the frame is finished means the frame
          // was cut short. Rewind so the whole frame goes out again. The
          // rewind takes priority over a coincident byte_done.
          if (ssel_rise) begin
            byte_data_send <= header_byte(last_grant);
            idx            <= 3'd0;
          end else if (byte_done) begin
            if (idx == LAST_IDX) begin
              byte_data_send <= IDLE_BYTE;
              idx            <= 3'd0;
              busy           <= 1'b0;
              state          <= IDLE;
            end else begin
              byte_data_send <= frame_byte(next_idx, last_grant, shadow);
              idx            <= next_idx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
